// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port arbiter and sequencer for a single-port 32-bit data memory.
// Port 0 is the CPU load/store unit, port 1 a secondary requester (DMA/debug).
// One request is granted per cycle and registered into a command stage that
// drives the memory; the command result is registered again into a per-port
// response stage, giving a fixed two-cycle accept-to-response latency.
// Build option: define DMEM_ARB_FIXED_PRIO_EN to give port 0 absolute priority
// on conflicts; without it conflicts are resolved round-robin.
module dmem_arbiter #(
  parameter int MEM_WORDS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // port 0 (CPU load/store unit)
  input  logic             p0_req_valid,
  output logic             p0_req_ready,
  input  logic             p0_req_write,
  input  logic [31:0]      p0_req_addr,
  input  logic [31:0]      p0_req_wdata,
  output logic             p0_rsp_valid,
  output logic [31:0]      p0_rsp_rdata,
  output logic             p0_rsp_err,
  // port 1 (secondary requester)
  input  logic             p1_req_valid,
  output logic             p1_req_ready,
  input  logic             p1_req_write,
  input  logic [31:0]      p1_req_addr,
  input  logic [31:0]      p1_req_wdata,
  output logic             p1_rsp_valid,
  output logic [31:0]      p1_rsp_rdata,
  output logic             p1_rsp_err,
  // memory side
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_write_data,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_read_data,
  // statistics
  output logic [CNT_W-1:0] conflict_count
);

  // One past the last valid byte address; 33 bits so the bound never wraps.
  localparam logic [32:0] LP_MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  // grant / request selection
  logic             w_both;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_acc;
  logic             w_port;
  logic             w_req_write;
  logic [31:0]      w_req_addr;
  logic [31:0]      w_req_wdata;
  logic             w_req_err;

  // command stage
  logic             r_cmd_vld_p1;
  logic             r_cmd_port_p1;
  logic             r_cmd_write_p1;
  logic [31:0]      r_cmd_addr_p1;
  logic [31:0]      r_cmd_wdata_p1;
  logic             r_cmd_err_p1;
  logic             w_mem_rd;
  logic             w_mem_wr;

  // response stage
  logic             r_rsp_vld0_p2;
  logic             r_rsp_vld1_p2;
  logic             r_rsp_err0_p2;
  logic             r_rsp_err1_p2;
  logic [31:0]      r_rsp_rdata0_p2;
  logic [31:0]      r_rsp_rdata1_p2;

  logic [CNT_W-1:0] r_conflict_cnt;

  assign w_both = p0_req_valid & p1_req_valid;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Grant selection: port 0 always wins a conflict
  always_comb begin
    w_gnt0 = p0_req_valid;
    w_gnt1 = p1_req_valid & ~p0_req_valid;
  end
`else
  // 1 = port 1 was granted most recently, so port 0 wins the next conflict.
  logic r_last_grant;

  // Grant selection: a lone requester wins; a conflict goes to the port not granted last
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_both) begin
      w_gnt0 = r_last_grant;
      w_gnt1 = ~r_last_grant;
    end else begin
      w_gnt0 = p0_req_valid;
      w_gnt1 = p1_req_valid;
    end
  end

  // Round-robin history, updated on every accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_acc) begin
      r_last_grant <= w_port;
    end
  end
`endif

  assign p0_req_ready = w_gnt0;
  assign p1_req_ready = w_gnt1;
  assign w_acc        = w_gnt0 | w_gnt1;
  assign w_port       = w_gnt1;

  // Request mux: forward the granted port's command and classify it
  always_comb begin
    w_req_write = p0_req_write;
    w_req_addr  = p0_req_addr;
    w_req_wdata = p0_req_wdata;
    if (w_port) begin
      w_req_write = p1_req_write;
      w_req_addr  = p1_req_addr;
      w_req_wdata = p1_req_wdata;
    end
    w_req_err = (w_req_addr[1:0] != 2'b00) || ({1'b0, w_req_addr} >= LP_MEM_BYTES);
  end

  // ---- stage p0 -> p1: command register ----
  // Command stage: capture the accepted request; address/data hold while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_vld_p1   <= 1'b0;
      r_cmd_port_p1  <= 1'b0;
      r_cmd_write_p1 <= 1'b0;
      r_cmd_addr_p1  <= '0;
      r_cmd_wdata_p1 <= '0;
      r_cmd_err_p1   <= 1'b0;
    end else begin
      r_cmd_vld_p1 <= w_acc;
      if (w_acc) begin
        r_cmd_port_p1  <= w_port;
        r_cmd_write_p1 <= w_req_write;
        r_cmd_addr_p1  <= w_req_addr;
        r_cmd_wdata_p1 <= w_req_wdata;
        r_cmd_err_p1   <= w_req_err;
      end
    end
  end

  // Blocked accesses never reach the memory; they still travel to the response.
  assign w_mem_rd       = r_cmd_vld_p1 & ~r_cmd_write_p1 & ~r_cmd_err_p1;
  assign w_mem_wr       = r_cmd_vld_p1 &  r_cmd_write_p1 & ~r_cmd_err_p1;
  assign mem_read       = w_mem_rd;
  assign mem_write      = w_mem_wr;
  assign mem_address    = r_cmd_addr_p1;
  assign mem_write_data = r_cmd_wdata_p1;

  // ---- stage p1 -> p2: response register ----
  // Response stage: route the command result to its port, capturing load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_vld0_p2   <= 1'b0;
      r_rsp_vld1_p2   <= 1'b0;
      r_rsp_err0_p2   <= 1'b0;
      r_rsp_err1_p2   <= 1'b0;
      r_rsp_rdata0_p2 <= '0;
      r_rsp_rdata1_p2 <= '0;
    end else begin
      r_rsp_vld0_p2   <= r_cmd_vld_p1 & ~r_cmd_port_p1;
      r_rsp_vld1_p2   <= r_cmd_vld_p1 &  r_cmd_port_p1;
      r_rsp_err0_p2   <= r_cmd_vld_p1 & ~r_cmd_port_p1 & r_cmd_err_p1;
      r_rsp_err1_p2   <= r_cmd_vld_p1 &  r_cmd_port_p1 & r_cmd_err_p1;
      r_rsp_rdata0_p2 <= (w_mem_rd && !r_cmd_port_p1) ? mem_read_data : '0;
      r_rsp_rdata1_p2 <= (w_mem_rd &&  r_cmd_port_p1) ? mem_read_data : '0;
    end
  end

  assign p0_rsp_valid = r_rsp_vld0_p2;
  assign p1_rsp_valid = r_rsp_vld1_p2;
  assign p0_rsp_err   = r_rsp_err0_p2;
  assign p1_rsp_err   = r_rsp_err1_p2;
  assign p0_rsp_rdata = r_rsp_rdata0_p2;
  assign p1_rsp_rdata = r_rsp_rdata1_p2;

  // Conflict counter: count cycles with both ports requesting, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_both && (r_conflict_cnt != {CNT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  assign conflict_count = r_conflict_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: drives both request ports, provides the data
// memory, and predicts every output cycle by cycle from a transaction-level
// model (grant rule, ordered access list, reference memory image).
module tb_dmem_arbiter;

  localparam logic [31:0] MEM_BYTES = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        p0_req_valid, p0_req_ready, p0_req_write, p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_write, p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;
  logic [15:0] conflict_count;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.MEM_WORDS(1024), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_read_data(mem_read_data), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0000_9E37);
  endfunction

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] mem [0:1023];
  logic        mem_init_done = 1'b0;
  assign mem_read_data = mem[mem_address[11:2]];
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (mem_write) begin
      mem[mem_address[11:2]] <= mem_write_data;
    end
  end

  // Everything observable, in one vector.
  logic [151:0] act_v, exp_v;
  assign act_v = {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err,
                  p0_rsp_rdata, p1_rsp_rdata, mem_read, mem_write, mem_address, mem_write_data,
                  conflict_count};

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    bit          port;
    bit          err;
    bit          wr;
    int          idx;
    logic [31:0] rdata;
    logic [31:0] old;
  } ent_t;

  ent_t        q[$];
  logic [31:0] ref_mem [0:1023];
  int          cyc = 0;
  bit          m_last = 1'b1;
  logic [15:0] m_cnt = '0;
  bit          m_vld = 0, m_wr = 0, m_err = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;

  // requester state
  bit          v[2], w[2], g[2];
  logic [31:0] a[2], d[2];

  task automatic apply_ports();
    p0_req_valid = v[0]; p0_req_write = w[0]; p0_req_addr = a[0]; p0_req_wdata = d[0];
    p1_req_valid = v[1]; p1_req_write = w[1]; p1_req_addr = a[1]; p1_req_wdata = d[1];
  endtask

  task automatic set_port(input int n, input bit vv, input bit ww, input logic [31:0] aa,
                          input logic [31:0] dd);
    v[n] = vv; w[n] = ww; a[n] = aa; d[n] = dd;
    apply_ports();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(99));
    if (r < 80)      return 32'($urandom_range(15)) * 4;
    else if (r < 88) return 32'($urandom_range(15)) * 4 + 32'($urandom_range(3, 1));
    else if (r < 94) return MEM_BYTES - 32'($urandom_range(4, 1)) * 4;
    else if (r < 98) return MEM_BYTES + 32'($urandom_range(7)) * 4;
    else             return 32'hFFFF_FFFC;
  endfunction

  task automatic drive_rand(input int busy);
    for (int n = 0; n < 2; n++) begin
      if (!v[n] || g[n]) begin
        v[n] = (int'($urandom_range(99)) < busy);
        w[n] = 1'($urandom_range(1));
        a[n] = rand_addr();
        d[n] = $urandom();
      end
    end
    apply_ports();
  endtask

  task automatic model_reset();
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].wr && !q[i].err && q[i].due > cyc) ref_mem[q[i].idx] = q[i].old;
    q.delete();
    m_last = 1'b1; m_cnt = '0; m_vld = 0; m_wr = 0; m_err = 0; m_addr = '0; m_wdata = '0;
    g[0] = 0; g[1] = 0;
  endtask

  // Evaluate one cycle at the falling edge: predict outputs, then advance the model.
  task automatic eval();
    bit          gn0, gn1, rv0, rv1, e0, e1, prt, wr, er;
    logic [31:0] r0, r1, ad, wd;
    ent_t        ep, en;
    @(negedge clk);
    gn0 = 0; gn1 = 0;
    if (p0_req_valid && p1_req_valid) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      gn0 = 1;
`else
      if (m_last) gn0 = 1; else gn1 = 1;
`endif
    end else begin
      gn0 = p0_req_valid;
      gn1 = p1_req_valid;
    end
    rv0 = 0; rv1 = 0; e0 = 0; e1 = 0; r0 = '0; r1 = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      ep = q.pop_front();
      if (ep.port) begin rv1 = 1; e1 = ep.err; r1 = ep.rdata; end
      else         begin rv0 = 1; e0 = ep.err; r0 = ep.rdata; end
    end
    exp_v = {gn0, gn1, rv0, rv1, e0, e1, r0, r1, m_vld & ~m_wr & ~m_err, m_vld & m_wr & ~m_err,
             m_addr, m_wdata, m_cnt};
    if (p0_req_valid && p1_req_valid && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_vld = gn0 | gn1;
    if (m_vld) begin
      prt = gn1;
      ad  = prt ? p1_req_addr  : p0_req_addr;
      wd  = prt ? p1_req_wdata : p0_req_wdata;
      wr  = prt ? p1_req_write : p0_req_write;
      er  = ((ad % 4) != 0) || (ad >= MEM_BYTES);
      en.due = cyc + 2; en.port = prt; en.err = er; en.wr = wr;
      en.idx = int'(ad[11:2]);
      en.old = ref_mem[en.idx];
      en.rdata = (!wr && !er) ? ref_mem[en.idx] : 32'h0;
      if (wr && !er) ref_mem[en.idx] = wd;
      q.push_back(en);
      m_wr = wr; m_err = er; m_addr = ad; m_wdata = wd; m_last = prt;
    end
    g[0] = gn0; g[1] = gn1;
    cyc++;
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    set_port(0, 0, 0, '0, '0);
    set_port(1, 0, 0, '0, '0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] old4;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (act_v !== '0) begin errors++; $display("FAIL reset_por got %h exp 0", act_v); end
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      drive_rand(80);
      eval();
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL reset_traffic c%0d got %h exp %h", cyc, act_v, exp_v); end
    end
    // asynchronous reset in the middle of a cycle with traffic in flight
    @(posedge clk); #2;
    set_port(0, 0, 0, '0, '0);
    set_port(1, 0, 0, '0, '0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (act_v !== '0) begin errors++; $display("FAIL reset_async got %h exp 0", act_v); end
    model_reset();
    @(posedge clk); #2 rst_n = 1'b1;
    // a store still in the command stage is dropped by reset
    @(posedge clk); #1;
    old4 = ref_mem[4];
    set_port(0, 1, 1, 32'h10, 32'hDEADBEEF);
    eval();
    checks++;
    if (act_v !== exp_v) begin errors++; $display("FAIL reset_store_acc got %h exp %h", act_v, exp_v); end
    @(posedge clk); #1;
    set_port(0, 0, 0, '0, '0);
    checks++;
    if (mem_write !== 1'b1) begin errors++; $display("FAIL reset_store_pending got %b exp 1", mem_write); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_memctl got %b exp 00", {mem_read, mem_write}); end
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (mem[4] !== old4) begin errors++; $display("FAIL reset_store_drop got %h exp %h", mem[4], old4); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_port();
    logic [5:0]  mask = '0;
    logic [31:0] ld = '0;
    logic        ld_err = 1'b1;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 0)      set_port(0, 1, 1, 32'h20, 32'h12345678);
      else if (c == 1) set_port(0, 1, 0, 32'h20, 32'h0);
      else             set_port(0, 0, 0, 32'h0, 32'h0);
      eval();
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL single_cycle c%0d got %h exp %h", c, act_v, exp_v); end
      if (p0_rsp_valid === 1'b1) begin
        mask[c] = 1'b1;
        if (c == 3) begin ld = p0_rsp_rdata; ld_err = p0_rsp_err; end
      end
    end
    checks++;
    if (mask !== 6'b001100) begin errors++; $display("FAIL single_rsp_timing got %b exp 001100", mask); end
    checks++;
    if ({ld_err, ld} !== {1'b0, 32'h12345678}) begin errors++; $display("FAIL single_load_data got %b/%h exp 0/12345678", ld_err, ld); end
  endtask

  task automatic test_back_to_back();
    int          n;
    logic [31:0] ad, x;
    for (int it = 0; it < 6; it++) begin
      n  = int'($urandom_range(1));
      ad = 32'($urandom_range(1023)) * 4;
      x  = $urandom();
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        set_port(1 - n, 0, 0, '0, '0);
        if (c == 0)      set_port(n, 1, 1, ad, x);
        else if (c == 1) set_port(n, 1, 0, ad, 32'h0);
        else             set_port(n, 0, 0, '0, '0);
        eval();
        checks++;
        if (act_v !== exp_v) begin errors++; $display("FAIL b2b_cycle it%0d c%0d got %h exp %h", it, c, act_v, exp_v); end
        if (c == 3) begin
          checks++;
          if ((n == 0 ? {p0_rsp_valid, p0_rsp_rdata} : {p1_rsp_valid, p1_rsp_rdata}) !== {1'b1, x})
            begin errors++; $display("FAIL b2b_load it%0d port%0d got %h exp %h", it, n,
                                     (n == 0 ? p0_rsp_rdata : p1_rsp_rdata), x); end
        end
      end
    end
  endtask

  task automatic test_conflict();
    int k[2];
    int seq[$];
    int exp_seq[4];
    int n0 = 0, n1 = 0;
    logic [15:0] exp_cnt;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 1, 1};
    exp_cnt = 16'd2;
`else
    exp_seq = '{0, 1, 0, 1};
    exp_cnt = 16'd3;
`endif
    apply_reset();
    k[0] = 0; k[1] = 0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (g[n]) k[n]++;
        set_port(n, k[n] < 2, 0, 32'(n * 64 + k[n] * 4), 32'h0);
      end
      eval();
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL conflict_cycle c%0d got %h exp %h", c, act_v, exp_v); end
      if (p0_req_ready === 1'b1) seq.push_back(0);
      else if (p1_req_ready === 1'b1) seq.push_back(1);
      if (p0_rsp_valid === 1'b1) n0++;
      if (p1_rsp_valid === 1'b1) n1++;
    end
    checks++;
    if (seq.size() != 4) begin errors++; $display("FAIL conflict_grants got %0d grants exp 4", seq.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seq[i] != exp_seq[i]) begin errors++; $display("FAIL conflict_order #%0d got P%0d exp P%0d", i, seq[i], exp_seq[i]); end
      end
    end
    checks++;
    if (conflict_count !== exp_cnt) begin errors++; $display("FAIL conflict_count got %0d exp %0d", conflict_count, exp_cnt); end
    checks++;
    if (n0 != 2 || n1 != 2) begin errors++; $display("FAIL conflict_rsp_ports got %0d/%0d exp 2/2", n0, n1); end
  endtask

  task automatic test_errors();
    logic [31:0] ffc;
    logic        touched = 1'b0;
    ffc = ref_mem[1023];
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      set_port(0, 0, 0, '0, '0);
      if (c == 0)      set_port(1, 1, 0, 32'h22, 32'h0);
      else if (c == 1) set_port(1, 1, 1, 32'h1000, 32'hA5A5A5A5);
      else if (c == 2) set_port(1, 1, 0, 32'hFFC, 32'h0);
      else             set_port(1, 0, 0, '0, '0);
      eval();
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL err_cycle c%0d got %h exp %h", c, act_v, exp_v); end
      if ((c == 1 || c == 2) && (mem_read !== 1'b0 || mem_write !== 1'b0)) touched = 1'b1;
      if (c == 2 || c == 3) begin
        checks++;
        if ({p1_rsp_valid, p1_rsp_err, p1_rsp_rdata} !== {1'b1, 1'b1, 32'h0})
          begin errors++; $display("FAIL err_rsp c%0d got %b/%b/%h exp 1/1/0", c, p1_rsp_valid, p1_rsp_err, p1_rsp_rdata); end
      end
      if (c == 3) begin
        checks++;
        if (mem_read !== 1'b1) begin errors++; $display("FAIL err_good_read got %b exp 1", mem_read); end
      end
      if (c == 4) begin
        checks++;
        if ({p1_rsp_valid, p1_rsp_err, p1_rsp_rdata} !== {1'b1, 1'b0, ffc})
          begin errors++; $display("FAIL err_good_load got %b/%b/%h exp 1/0/%h", p1_rsp_valid, p1_rsp_err, p1_rsp_rdata, ffc); end
      end
    end
    checks++;
    if (touched !== 1'b0) begin errors++; $display("FAIL err_mem_blocked got 1 exp 0"); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      drive_rand(c < 250 ? 90 : 50);
      eval();
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL rand_cycle c%0d got %h exp %h", c, act_v, exp_v); end
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      set_port(0, 0, 0, '0, '0);
      set_port(1, 0, 0, '0, '0);
      eval();
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL rand_drain c%0d got %h exp %h", c, act_v, exp_v); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] near = '0;
    apply_reset();
    for (int c = 0; c < 65536 + 5; c++) begin
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (!v[n] || g[n]) set_port(n, 1, 0, 32'($urandom_range(1023)) * 4, 32'h0);
      end
      eval();
      checks++;
      if (act_v !== exp_v) begin errors++; $display("FAIL sat_cycle c%0d got %h exp %h", c, act_v, exp_v); end
      if (c == 65534) near = conflict_count;
    end
    checks++;
    if (near !== 16'hFFFE) begin errors++; $display("FAIL sat_near got %h exp fffe", near); end
    checks++;
    if (conflict_count !== 16'hFFFF) begin errors++; $display("FAIL sat_final got %h exp ffff", conflict_count); end
    @(posedge clk); #1;
    set_port(0, 0, 0, '0, '0);
    set_port(1, 0, 0, '0, '0);
    eval();
    checks++;
    if (conflict_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", conflict_count); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    for (int n = 0; n < 2; n++) begin v[n] = 0; w[n] = 0; g[n] = 0; a[n] = '0; d[n] = '0; end
    apply_ports();
    test_reset();
    test_single_port();
    test_back_to_back();
    test_conflict();
    test_errors();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
